// File: rtl/crossbar_port_arbiter.sv
// Per-output round-robin arbiter and path scheduler for one crossbar stage.
// Each output runs an independent IDLE/BUSY FSM. The FSM grants one requesting
// input, holds that path until done, abort or hold timeout, and then returns
// to IDLE before it arbitrates again.
module crossbar_port_arbiter #(
  parameter int unsigned NPORT   = 4,
  parameter int unsigned SELW    = 2,
  parameter int unsigned MAXHOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT*SELW-1:0]   dest,
  input  logic [NPORT-1:0]        done,
  output logic [NPORT-1:0]        gnt,
  output logic [NPORT*SELW-1:0]   out_sel,
  output logic [NPORT-1:0]        out_vld,
  output logic [NPORT-1:0]        timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  logic [NPORT-1:0]      gnt_q, gnt_d;
  logic [NPORT-1:0]      vld_d_all;
  logic [NPORT*SELW-1:0] sel_d_all;

  for (genvar j = 0; j < NPORT; j++) begin : g_out
    state_e          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] rr_q, rr_d;
    logic [SELW-1:0] win;
    logic            vld_q, vld_d;
    logic            to_q, to_d;
    logic            found;
    logic            start;
    logic            busy_run;
    logic            expire;
    logic            own_done;
    logic            own_req;
    logic [NPORT-1:0] cand;

    // Inputs already holding a path are excluded, so a dest change while
    // granted cannot produce a second grant.
    always_comb begin
      cand = '0;
      for (int i = 0; i < int'(NPORT); i++) begin
        cand[i] = req[i] && (dest[i*SELW +: SELW] == SELW'(j)) && !gnt_q[i];
      end
    end

    // Round-robin scan starting at rr_q, wrapping modulo NPORT.
    always_comb begin : p_scan
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < int'(NPORT); k++) begin
        idx = int'(rr_q) + k;
        if (idx >= int'(NPORT)) idx = idx - int'(NPORT);
        if (!found && cand[idx]) begin
          found = 1'b1;
          win   = SELW'(idx);
        end
      end
    end

    assign own_done = done[sel_q];
    assign own_req  = req[sel_q];
    assign busy_run = (state_q == StBusy);

    // Next-state of the output FSM and its registered outputs.
    always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      vld_d   = vld_q;
      rr_d    = rr_q;
      to_d    = 1'b0;
      start   = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_d = StBusy;
            sel_d   = win;
            vld_d   = 1'b1;
            rr_d    = (int'(win) == int'(NPORT) - 1) ? '0 : win + 1'b1;
            start   = 1'b1;
          end
        end
        StBusy: begin
          if (own_done || !own_req || expire) begin
            state_d = StIdle;
            vld_d   = 1'b0;
            sel_d   = '0;
            // done on the expiry cycle wins: plain release, no timeout pulse
            to_d    = expire && !own_done;
          end
        end
      endcase
    end

    // FSM state, round-robin pointer and registered per-output signals.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= StIdle;
        sel_q   <= '0;
        vld_q   <= 1'b0;
        rr_q    <= '0;
        to_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
        vld_q   <= vld_d;
        rr_q    <= rr_d;
        to_q    <= to_d;
      end
    end

    if (MAXHOLD > 0) begin : g_hold
      localparam int unsigned     HW       = $clog2(MAXHOLD + 1);
      localparam logic [HW-1:0]   HoldLast = HW'(MAXHOLD - 1);
      logic [HW-1:0] hold_q, hold_d;

      // Count BUSY cycles since the grant, saturating.
      always_comb begin
        hold_d = hold_q;
        if (start) begin
          hold_d = '0;
        end else if (busy_run && (hold_q != '1)) begin
          hold_d = hold_q + 1'b1;
        end
      end

      // Hold counter register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= '0;
        else      hold_q <= hold_d;
      end

      assign expire = busy_run && (hold_q == HoldLast);
    end else begin : g_nohold
      assign expire = 1'b0;
    end

    assign vld_d_all[j]                 = vld_d;
    assign sel_d_all[j*SELW +: SELW]    = sel_d;
    assign out_vld[j]                   = vld_q;
    assign out_sel[j*SELW +: SELW]      = sel_q;
    assign timeout[j]                   = to_q;
  end

  // An input is granted when any output will be owned by it.
  always_comb begin
    gnt_d = '0;
    for (int j = 0; j < int'(NPORT); j++) begin
      if (vld_d_all[j]) gnt_d[sel_d_all[j*SELW +: SELW]] = 1'b1;
    end
  end

  // Registered grant vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gnt_q <= '0;
    else      gnt_q <= gnt_d;
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_crossbar_port_arbiter.sv
// Directed bench for crossbar_port_arbiter (NPORT=4, SELW=2, MAXHOLD=8).
module tb_crossbar_port_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] dest;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [7:0] out_sel;
  logic [3:0] out_vld;
  logic [3:0] timeout;

  int checks;
  int errors;

  crossbar_port_arbiter #(
    .NPORT  (4),
    .SELW   (2),
    .MAXHOLD(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .dest   (dest),
    .done   (done),
    .gnt    (gnt),
    .out_sel(out_sel),
    .out_vld(out_vld),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_dest(input int i, input logic [1:0] v);
    dest[i*2 +: 2] = v;
  endtask

  initial begin
    logic [1:0] order [4];
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    req    = 4'hF;
    dest   = 8'h00;
    done   = 4'h0;

    // Reset held with all inputs requesting output 0.
    repeat (3) tick();
    check("rst_gnt", {28'd0, gnt}, 32'h0);
    check("rst_vld", {28'd0, out_vld}, 32'h0);
    check("rst_sel", {24'd0, out_sel}, 32'h0);
    check("rst_to", {28'd0, timeout}, 32'h0);
    rst = 1'b1;
    tick();
    check("first_gnt", {28'd0, gnt}, 32'h1);
    check("first_vld", {28'd0, out_vld}, 32'h1);
    req = 4'h0;
    tick();
    check("abort_gnt", {28'd0, gnt}, 32'h0);

    // Single grant: input 2 to output 1.
    req = 4'b0100;
    set_dest(2, 2'd1);
    tick();
    check("single_gnt", {28'd0, gnt}, 32'h4);
    check("single_vld", {28'd0, out_vld}, 32'h2);
    check("single_sel", {24'd0, out_sel}, 32'h08);
    tick();
    tick();
    done = 4'b0100;
    tick();
    done = 4'h0;
    req  = 4'h0;
    check("single_rel_gnt", {28'd0, gnt}, 32'h0);
    check("single_rel_vld", {28'd0, out_vld}, 32'h0);
    check("single_rel_to", {28'd0, timeout}, 32'h0);

    // Contention on output 2 by inputs 0, 1, 3.
    order[0] = 2'd0;
    order[1] = 2'd1;
    order[2] = 2'd3;
    order[3] = 2'd0;
    set_dest(0, 2'd2);
    set_dest(1, 2'd2);
    set_dest(2, 2'd2);
    set_dest(3, 2'd2);
    req = 4'b1011;
    tick();
    for (int r = 0; r < 4; r++) begin
      check($sformatf("rr%0d_gnt", r), {28'd0, gnt}, 32'h1 << order[r]);
      check($sformatf("rr%0d_sel", r), {30'd0, out_sel[5:4]}, {30'd0, order[r]});
      check($sformatf("rr%0d_vld", r), {28'd0, out_vld}, 32'h4);
      tick();
      done = 4'h1 << order[r];
      tick();
      done = 4'h0;
      check($sformatf("rr%0d_bubble", r), {28'd0, gnt}, 32'h0);
      if (r == 3) req = 4'h0;
      tick();
    end
    check("rr_idle", {28'd0, out_vld}, 32'h0);

    // Full parallel permutation 0->3, 1->2, 2->1, 3->0.
    dest = 8'h1B;
    req  = 4'hF;
    tick();
    check("perm_gnt", {28'd0, gnt}, 32'hF);
    check("perm_vld", {28'd0, out_vld}, 32'hF);
    check("perm_sel", {24'd0, out_sel}, 32'h1B);
    req = 4'h0;
    tick();
    check("perm_rel", {28'd0, gnt}, 32'h0);

    // Rotate output 0 pointer back to 0 via a grant to input 3.
    dest = 8'h00;
    req  = 4'b1000;
    tick();
    check("rot_gnt", {28'd0, gnt}, 32'h8);
    req = 4'h0;
    tick();

    // Timeout: input 0 holds output 0 without done, input 1 waits.
    req = 4'b0011;
    tick();
    check("to_first_gnt", {28'd0, gnt}, 32'h1);
    repeat (7) tick();
    check("to_held_vld", {28'd0, out_vld}, 32'h1);
    check("to_held_to", {28'd0, timeout}, 32'h0);
    tick();
    check("to_fall_vld", {28'd0, out_vld}, 32'h0);
    check("to_pulse", {28'd0, timeout}, 32'h1);
    check("to_fall_gnt", {28'd0, gnt}, 32'h0);
    tick();
    check("to_pulse_end", {28'd0, timeout}, 32'h0);
    check("to_next_gnt", {28'd0, gnt}, 32'h2);
    check("to_next_sel", {24'd0, out_sel}, 32'h01);

    // done coinciding with expiry: release without timeout pulse.
    repeat (7) tick();
    check("dto_held_vld", {28'd0, out_vld}, 32'h1);
    done = 4'b0010;
    tick();
    done = 4'h0;
    check("dto_vld", {28'd0, out_vld}, 32'h0);
    check("dto_no_to", {28'd0, timeout}, 32'h0);
    tick();
    check("dto_regrant", {28'd0, gnt}, 32'h1);

    // Second busy output, then asynchronous reset mid-operation.
    set_dest(2, 2'd3);
    req = 4'b0111;
    tick();
    check("mid_gnt", {28'd0, gnt}, 32'h5);
    check("mid_vld", {28'd0, out_vld}, 32'h9);
    #1;
    rst = 1'b0;
    #1;
    check("async_gnt", {28'd0, gnt}, 32'h0);
    check("async_vld", {28'd0, out_vld}, 32'h0);
    check("async_sel", {24'd0, out_sel}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_gnt", {28'd0, gnt}, 32'h5);
    check("post_rst_sel", {24'd0, out_sel}, 32'h80);
    req = 4'h0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
